// File: rtl/lbp_hist.sv
// rtl/lbp_hist.sv - 256-bin LBP code histogram over one frame, drained bin-by-bin on finish
// Optional border exclusion: define LBP_HIST_SKIP_BORDER_EN.
module lbp_hist #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int CNT_W = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lbp_valid,
  input  logic [13:0]      lbp_addr,
  input  logic [7:0]       lbp_data,
  input  logic             finish,
  output logic             hist_valid,
  input  logic             hist_ready,
  output logic [7:0]       hist_bin,
  output logic [CNT_W-1:0] hist_count,
  output logic [CNT_W-1:0] hist_total,
  output logic             hist_done,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  logic [CNT_W-1:0] bins_q [256];
  logic [CNT_W-1:0] total_q;
  logic [7:0]       ptr_q;
  logic             hist_valid_q;
  logic [7:0]       hist_bin_q;
  logic [CNT_W-1:0] hist_count_q;
  logic             hist_done_q;

  logic             in_frame;
  logic             keep;
  logic             cnt_en;
  logic             xfer;
  logic [CNT_W-1:0] bin_inc_d;
  logic [CNT_W-1:0] total_d;
  logic [7:0]       ptr_d;

  assign in_frame = lbp_valid & ((state_q == IDLE) | (state_q == ACCUM));

`ifdef LBP_HIST_SKIP_BORDER_EN
  logic [13:0] row;
  logic [13:0] col;
  assign row  = lbp_addr / 14'(IMG_W);
  assign col  = lbp_addr % 14'(IMG_W);
  assign keep = !((row == '0) || (row == 14'(IMG_H - 1)) ||
                  (col == '0) || (col == 14'(IMG_W - 1)));
`else
  logic unused_addr;
  assign unused_addr = ^lbp_addr;
  assign keep        = 1'b1;
`endif

  // Border samples still count as frame activity for the IDLE->ACCUM move.
  assign cnt_en    = in_frame & keep;
  assign bin_inc_d = (bins_q[lbp_data] == CNT_MAX) ? CNT_MAX : bins_q[lbp_data] + CNT_W'(1);
  assign total_d   = (total_q == CNT_MAX) ? CNT_MAX : total_q + CNT_W'(1);
  assign xfer      = (state_q == DRAIN) & hist_valid_q & hist_ready;
  assign ptr_d     = ptr_q + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      for (int i = 0; i < 256; i++) bins_q[i] <= '0;
      total_q      <= '0;
      ptr_q        <= '0;
      hist_valid_q <= 1'b0;
      hist_bin_q   <= '0;
      hist_count_q <= '0;
      hist_done_q  <= 1'b0;
    end else begin
      hist_done_q <= 1'b0;
      if (cnt_en) begin
        bins_q[lbp_data] <= bin_inc_d;
        total_q          <= total_d;
      end
      case (state_q)
        IDLE: begin
          if (in_frame) state_q <= ACCUM;
        end
        ACCUM: begin
          if (finish) begin
            state_q      <= DRAIN;
            ptr_q        <= '0;
            hist_valid_q <= 1'b1;
            hist_bin_q   <= '0;
            // A same-cycle sample into bin 0 must be visible in the first beat.
            hist_count_q <= (cnt_en && (lbp_data == 8'd0)) ? bin_inc_d : bins_q[0];
          end
        end
        DRAIN: begin
          if (xfer) begin
            bins_q[ptr_q] <= '0;
            if (ptr_q == 8'hFF) begin
              state_q      <= DONE;
              hist_valid_q <= 1'b0;
              hist_bin_q   <= '0;
              hist_count_q <= '0;
              hist_done_q  <= 1'b1;
            end else begin
              ptr_q        <= ptr_d;
              hist_bin_q   <= ptr_d;
              hist_count_q <= bins_q[ptr_d];
            end
          end
        end
        DONE: begin
          total_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hist_valid = hist_valid_q;
  assign hist_bin   = hist_bin_q;
  assign hist_count = hist_count_q;
  assign hist_total = total_q;
  assign hist_done  = hist_done_q;
  assign busy       = (state_q == ACCUM) | (state_q == DRAIN);

endmodule

// File: tb/tb_lbp_hist.sv
// tb/tb_lbp_hist.sv - self-checking bench for lbp_hist against a frame-level histogram model
module tb_lbp_hist;

  logic        clk;
  logic        reset;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  logic        hist_valid;
  logic        hist_ready;
  logic [7:0]  hist_bin;
  logic [14:0] hist_count;
  logic [14:0] hist_total;
  logic        hist_done;
  logic        busy;

  lbp_hist dut (
    .clk        (clk),
    .reset      (reset),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .hist_valid (hist_valid),
    .hist_ready (hist_ready),
    .hist_bin   (hist_bin),
    .hist_count (hist_count),
    .hist_total (hist_total),
    .hist_done  (hist_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int unsigned mbins [256];
  int unsigned mtotal;
  int unsigned recv [256];
  int          exp_idx;
  int          done_seen;
  int          cyc;
  int          first_valid_cyc;
  int          done_cyc;
  bit          prev_stall;
  logic [7:0]  prev_bin;
  logic [14:0] prev_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit is_border(input int addr);
    int row = addr / 128;
    int col = addr % 128;
    return (row == 0) || (row == 127) || (col == 0) || (col == 127);
  endfunction

  function automatic void add_sample(input int addr, input int code);
`ifdef LBP_HIST_SKIP_BORDER_EN
    if (is_border(addr)) return;
`endif
    mbins[code] = mbins[code] + 1;
    mtotal = mtotal + 1;
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 256; i++) begin
      mbins[i] = 0;
      recv[i]  = 0;
    end
    mtotal = 0;
  endfunction

  // Per-cycle compare of the drain stream against the model.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (hist_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (exp_idx > 255) begin
          check("bin_overrun", exp_idx, 255);
        end else begin
          check("bin_order", hist_bin, exp_idx);
          check("bin_count", hist_count, mbins[exp_idx]);
          check("drain_total", hist_total, mtotal);
          if (prev_stall) begin
            check("stall_bin_stable", hist_bin, prev_bin);
            check("stall_cnt_stable", hist_count, prev_cnt);
          end
          prev_stall = !hist_ready;
          prev_bin   = hist_bin;
          prev_cnt   = hist_count;
          if (hist_ready) begin
            recv[exp_idx]  = hist_count;
            mbins[exp_idx] = 0;
            exp_idx++;
          end
        end
      end else begin
        prev_stall = 1'b0;
      end
      if (hist_done) begin
        done_seen++;
        done_cyc = cyc;
        check("done_after_255", exp_idx, 256);
      end
    end
  end

  task automatic send(input int addr, input int code, input bit fin);
    lbp_valid = 1'b1;
    lbp_addr  = addr[13:0];
    lbp_data  = code[7:0];
    finish    = fin;
    add_sample(addr, code);
    @(posedge clk); #1;
    lbp_valid = 1'b0;
  endtask

  task automatic drain(input bit backpressure);
    int d0;
    bit pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    d0 = done_seen;
    exp_idx = 0;
    prev_stall = 1'b0;
    first_valid_cyc = -1;
    finish = 1'b1;
    for (int c = 0; c < 3000 && done_seen == d0; c++) begin
      if (!backpressure)  hist_ready = 1'b1;
      else if (c < 40)    hist_ready = pat[c % 4];
      else                hist_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    hist_ready = 1'b0;
    check("drain_done_seen", done_seen, d0 + 1);
    check("drain_all_bins", exp_idx, 256);
    check("total_cleared", hist_total, 0);
    check("busy_after_done", busy, 0);
    mtotal = 0;
    // finish is still high: it must not restart a drain from IDLE.
    repeat (3) @(posedge clk);
    #1;
    check("stale_finish_valid", hist_valid, 0);
    check("stale_finish_busy", busy, 0);
    finish = 1'b0;
  endtask

  initial begin
    int bad;
    reset = 1'b1; lbp_valid = 1'b0; lbp_addr = '0; lbp_data = '0;
    finish = 1'b0; hist_ready = 1'b0;
    exp_idx = 0; done_seen = 0; cyc = 0; first_valid_cyc = -1; done_cyc = 0;
    prev_stall = 1'b0; prev_bin = '0; prev_cnt = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", hist_valid, 0);
    check("rst_bin", hist_bin, 0);
    check("rst_count", hist_count, 0);
    check("rst_total", hist_total, 0);
    check("rst_done", hist_done, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    // Frame A: all codes zero, ready held high.
    for (int a = 0; a < 16384; a++) send(a, 0, 1'b0);
`ifdef LBP_HIST_SKIP_BORDER_EN
    check("A_model_bin0", mbins[0], 15876);
    check("A_dut_total", hist_total, 15876);
`else
    check("A_model_bin0", mbins[0], 16384);
    check("A_dut_total", hist_total, 16384);
`endif
    check("A_busy_accum", busy, 1);
    drain(1'b0);
`ifdef LBP_HIST_SKIP_BORDER_EN
    check("A_recv_bin0", recv[0], 15876);
`else
    check("A_recv_bin0", recv[0], 16384);
`endif
    check("A_recv_bin1", recv[1], 0);
    check("A_recv_bin255", recv[255], 0);
    check("A_done_latency", done_cyc - first_valid_cyc, 256);

    // Frame B: code = addr[7:0], drained under backpressure.
    for (int a = 0; a < 16384; a++) send(a, a % 256, 1'b0);
`ifdef LBP_HIST_SKIP_BORDER_EN
    check("B_model_total", mtotal, 15876);
`else
    check("B_model_total", mtotal, 16384);
`endif
    drain(1'b1);
    bad = 0;
`ifdef LBP_HIST_SKIP_BORDER_EN
    check("B_recv_bin0", recv[0], 0);
    check("B_recv_bin1", recv[1], 63);
`else
    for (int i = 0; i < 256; i++) if (recv[i] != 64) bad++;
    check("B_bins_not_64", bad, 0);
`endif

    // Frame C: five back-to-back 0xA5, then 0x10 in the same cycle as finish.
    clear_model();
    for (int i = 0; i < 5; i++) send(200 + i, 8'hA5, 1'b0);
    check("C_total_5", hist_total, 5);
    check("C_model_a5", mbins[8'hA5], 5);
    send(300, 8'h10, 1'b1);
    drain(1'b0);
    check("C_recv_a5", recv[8'hA5], 5);
    check("C_recv_10", recv[8'h10], 1);
    check("C_recv_00", recv[0], 0);

    // Frame D: reset in the middle of the drain at bin 100.
    clear_model();
    for (int a = 0; a < 1024; a++) send(a, a % 256, 1'b0);
    exp_idx = 0; prev_stall = 1'b0; first_valid_cyc = -1;
    finish = 1'b1;
    for (int c = 0; c < 1000 && exp_idx < 100; c++) begin
      hist_ready = 1'b1;
      @(posedge clk); #1;
    end
    check("D_reached_100", exp_idx, 100);
    reset = 1'b1;
    #1;
    check("D_rst_valid", hist_valid, 0);
    check("D_rst_bin", hist_bin, 0);
    check("D_rst_count", hist_count, 0);
    check("D_rst_total", hist_total, 0);
    check("D_rst_busy", busy, 0);
    hist_ready = 1'b0; finish = 1'b0;
    clear_model();
    @(posedge clk); #1;
    reset = 1'b0;

    // Frame E: ten samples of code 1 after the aborted frame.
    for (int i = 0; i < 10; i++) send(500 + i, 1, 1'b0);
    drain(1'b0);
    check("E_recv_bin1", recv[1], 10);
    check("E_recv_bin0", recv[0], 0);
    check("E_recv_bin200", recv[200], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lbp_hist.md
Name: lbp_hist

Overview:
- Downstream consumer of the LBP engine's output stream (lbp_valid/lbp_addr/lbp_data).
- Snoops each written LBP code and accumulates a 256-bin histogram over one 128x128 frame.
- When the LBP engine raises finish, streams all 256 bin counts out over a valid/ready port for the feature/classifier stage.
- Then re-arms for the next frame.

Parameters:
- IMG_W, 128, image width in pixels; used for border detection.
- IMG_H, 128, image height in pixels.
- CNT_W, 15, bin counter width; must hold IMG_W*IMG_H (16384).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- lbp_valid  in  1  LBP engine writes a code this cycle.
- lbp_addr  in  14  pixel address, row*IMG_W + col.
- lbp_data  in  8  LBP code, used as bin index.
- finish  in  1  LBP engine frame complete; level, held high.
- hist_valid  out  1  hist_bin/hist_count valid.
- hist_ready  in  1  downstream accepts the current bin.
- hist_bin  out  8  bin index being presented.
- hist_count  out  CNT_W  count for hist_bin.
- hist_total  out  CNT_W  number of samples accumulated this frame.
- hist_done  out  1  one-cycle pulse after bin 255 is accepted.
- busy  out  1  high in ACCUM or DRAIN.

Behaviour:
- Storage: 256 x CNT_W counter registers, cleared by reset.
- Reset values: all outputs 0; all bins 0; hist_total 0; state IDLE.
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - First lbp_valid moves the FSM to ACCUM and that sample is counted.
  - finish high while in IDLE (stale from the previous frame) is ignored until at least one sample has been accumulated.
- ACCUM:
  - On each lbp_valid, bin[lbp_data] += 1 and hist_total += 1, in the same cycle, with no pipeline hazard.
  - Back-to-back samples to the same bin must each count.
  - Counters saturate at 2^CNT_W-1; no wrap.
  - finish high moves the FSM to DRAIN on the next edge. An lbp_valid in the same cycle as finish is still counted.
  - lbp_valid outside ACCUM/IDLE is ignored.
- DRAIN:
  - Internal pointer starts at 0.
  - hist_valid=1, hist_bin=pointer, hist_count=bin[pointer].
  - Outputs are registered and held stable while hist_ready=0.
  - A transfer occurs on the posedge where hist_valid & hist_ready are both high; the pointer then increments.
  - Throughput is one bin per cycle when hist_ready is held high.
  - Each bin is cleared to 0 as it is transferred.
  - Transfer of bin 255 moves the FSM to DONE.
  - hist_valid drops the cycle after the final transfer.
- DONE:
  - hist_done=1 for exactly one cycle.
  - hist_total is cleared.
  - FSM returns to IDLE.
  - The histogram is now all-zero, ready for the next frame.
- busy = (state==ACCUM) | (state==DRAIN).
- Reset at any point (mid-ACCUM or mid-DRAIN) immediately clears all bins, the pointer and the outputs, and returns the FSM to IDLE. No partial frame survives.
- Duplicate writes to the same lbp_addr are counted each time; no address tracking.

Optional Feature:
- Macro: LBP_HIST_SKIP_BORDER_EN.
- Defined:
  - Samples with row==0, row==IMG_H-1, col==0 or col==IMG_W-1 are excluded from both the bins and hist_total.
  - row = lbp_addr/IMG_W, col = lbp_addr%IMG_W.
  - A full frame then yields hist_total = (IMG_W-2)*(IMG_H-2) = 15876.
  - Border samples still trigger the IDLE->ACCUM transition.
- Undefined: every lbp_valid sample is counted; a full frame yields hist_total = 16384.

Test Plan:
- Full frame, all codes 0x00, hist_ready=1:
  - Without the macro: bin0=16384, bins 1..255 = 0, hist_total=16384.
  - hist_done pulses exactly 256 cycles after DRAIN entry.
- Frame with codes lbp_data = addr[7:0] over 16384 samples:
  - Every bin count = 64.
  - With LBP_HIST_SKIP_BORDER_EN, hist_total = 15876 and the bins match the golden border-excluded tally.
- Back-to-back same bin: 5 consecutive lbp_valid cycles with code 0xA5 -> bin 0xA5 = 5, hist_total = 5.
- Drain backpressure: hist_ready toggled 1,0,0,1 pseudo-randomly:
  - hist_bin/hist_count stable while stalled.
  - Bins are received in order 0..255 with no drops or duplicates.
- Simultaneous finish and lbp_valid (code 0x10) in the final cycle -> that sample is included; bin 0x10 is incremented.
- Reset asserted mid-DRAIN at bin 100:
  - All outputs go to 0 and state is IDLE.
  - The next frame of 10 samples of code 0x01 yields bin1=10 and all other bins 0.
